// File: rtl/count_range_param.sv
// Bounded up/down event counter with runtime lo/hi limits, wrap or saturate at the bounds,
// synchronous load and a sticky range error flag.
module count_range_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             at_lo,
  output logic             at_hi,
  output logic             cfg_err,
  output logic             range_err
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  logic [WIDTH-1:0] count_p0;
  logic             wrap_p0;
  logic             sat_p0;
  logic             range_err_p0;

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;
  logic             range_err_nxt;

  logic             cnt_below;
  logic             cnt_above;
  logic             load_ok;
  logic [WIDTH:0]   room_up;
  logic [WIDTH:0]   room_dn;

  // Headroom is taken one bit wider than the count so that a full-range
  // distance never aliases with a short one.
  function automatic logic [WIDTH:0] headroom(input logic [WIDTH-1:0] upper,
                                              input logic [WIDTH-1:0] lower);
    return {1'b0, upper} - {1'b0, lower};
  endfunction

  function automatic logic step_fits(input logic [WIDTH:0] room);
    return room >= STEP_X;
  endfunction

  // Only called once step_fits() has proven the result stays inside the bounds.
  function automatic logic [WIDTH-1:0] add_step(input logic [WIDTH-1:0] c);
    return c + STEP_N;
  endfunction

  function automatic logic [WIDTH-1:0] sub_step(input logic [WIDTH-1:0] c);
    return c - STEP_N;
  endfunction

  assign cfg_err   = lo > hi;
  assign cnt_below = count_p0 < lo;
  assign cnt_above = count_p0 > hi;
  assign load_ok   = (load_val >= lo) && (load_val <= hi);
  assign room_up   = headroom(hi, count_p0);
  assign room_dn   = headroom(count_p0, lo);

  always_comb begin
    count_nxt     = count_p0;
    wrap_nxt      = 1'b0;
    sat_nxt       = 1'b0;
    range_err_nxt = range_err_p0;
    if (cfg_err) begin
      count_nxt = count_p0;
    end else if (load) begin
      if (load_ok) begin
        count_nxt = load_val;
      end else begin
        count_nxt     = lo;
        range_err_nxt = 1'b1;
      end
    end else if (enable) begin
      if (cnt_below || cnt_above) begin
        // Bounds moved underneath the count: snap to the bound we are heading from.
        count_nxt     = dir ? hi : lo;
        range_err_nxt = 1'b1;
      end else if (!dir) begin
        if (step_fits(room_up)) begin
          count_nxt = add_step(count_p0);
        end else if (mode) begin
          count_nxt = hi;
          sat_nxt   = 1'b1;
        end else begin
          count_nxt = lo;
          wrap_nxt  = 1'b1;
        end
      end else begin
        if (step_fits(room_dn)) begin
          count_nxt = sub_step(count_p0);
        end else if (mode) begin
          count_nxt = lo;
          sat_nxt   = 1'b1;
        end else begin
          count_nxt = hi;
          wrap_nxt  = 1'b1;
        end
      end
    end
  end

  // Stage p0: registered count and event flags
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p0     <= '0;
      wrap_p0      <= 1'b0;
      sat_p0       <= 1'b0;
      range_err_p0 <= 1'b0;
    end else begin
      count_p0     <= count_nxt;
      wrap_p0      <= wrap_nxt;
      sat_p0       <= sat_nxt;
      range_err_p0 <= range_err_nxt;
    end
  end

  assign count     = count_p0;
  assign wrap      = wrap_p0;
  assign sat       = sat_p0;
  assign range_err = range_err_p0;
  assign at_lo     = count_p0 == lo;
  assign at_hi     = count_p0 == hi;

endmodule

// File: tb/tb_count_range_param.sv
// Directed bench for count_range_param: a 16-bit full-range unit and an
// 8-bit bounded unit with STEP=3, checked against hand-computed values.
module tb_count_range_param;

  logic clk;
  logic rst;

  logic        en16, dir16, mode16, load16;
  logic [15:0] lo16, hi16, lv16, count16;
  logic        wrap16, sat16, atlo16, athi16, cfg16, rerr16;

  logic        en8, dir8, mode8, load8;
  logic [7:0]  lo8, hi8, lv8, count8;
  logic        wrap8, sat8, atlo8, athi8, cfg8, rerr8;

  int n_cmp;
  int n_bad;

  count_range_param #(.WIDTH(16), .STEP(1)) dut16 (
    .clk(clk), .rst(rst), .enable(en16), .dir(dir16), .mode(mode16),
    .lo(lo16), .hi(hi16), .load(load16), .load_val(lv16),
    .count(count16), .wrap(wrap16), .sat(sat16), .at_lo(atlo16), .at_hi(athi16),
    .cfg_err(cfg16), .range_err(rerr16)
  );

  count_range_param #(.WIDTH(8), .STEP(3)) dut8 (
    .clk(clk), .rst(rst), .enable(en8), .dir(dir8), .mode(mode8),
    .lo(lo8), .hi(hi8), .load(load8), .load_val(lv8),
    .count(count8), .wrap(wrap8), .sat(sat8), .at_lo(atlo8), .at_hi(athi8),
    .cfg_err(cfg8), .range_err(rerr8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full visible state of the 8-bit unit.
  task automatic chk8(input string tag, input logic [7:0] c, input logic w,
                      input logic s, input logic e);
    chk({tag, ".count"}, 32'(count8), 32'(c));
    chk({tag, ".wrap"},  32'(wrap8),  32'(w));
    chk({tag, ".sat"},   32'(sat8),   32'(s));
    chk({tag, ".rerr"},  32'(rerr8),  32'(e));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    en16 = 1'b1; dir16 = 1'b0; mode16 = 1'b0; load16 = 1'b0;
    lo16 = 16'h0000; hi16 = 16'hFFFF; lv16 = 16'h0000;
    en8 = 1'b0; dir8 = 1'b0; mode8 = 1'b0; load8 = 1'b0;
    lo8 = 8'd10; hi8 = 8'd20; lv8 = 8'd0;

    // Reset with enable held high
    repeat (5) tick();
    chk("rst16.count", 32'(count16), 32'd0);
    chk("rst16.wrap",  32'(wrap16),  32'd0);
    chk("rst16.atlo",  32'(atlo16),  32'd1);
    chk8("rst8", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Free-run from zero
    tick(); chk("free.1", 32'(count16), 32'd1);
    tick(); chk("free.2", 32'(count16), 32'd2);
    tick(); chk("free.3", 32'(count16), 32'd3);

    // Jump near the top and roll over
    load16 = 1'b1; lv16 = 16'hFFFE;
    tick(); load16 = 1'b0;
    chk("top.fffe", 32'(count16), 32'h0000FFFE);
    chk("top.athi0", 32'(athi16), 32'd0);
    tick();
    chk("top.ffff", 32'(count16), 32'h0000FFFF);
    chk("top.athi1", 32'(athi16), 32'd1);
    chk("top.wrap0", 32'(wrap16), 32'd0);
    tick();
    chk("roll.count", 32'(count16), 32'd0);
    chk("roll.wrap",  32'(wrap16),  32'd1);
    chk("roll.athi",  32'(athi16),  32'd0);
    tick();
    chk("post.count", 32'(count16), 32'd1);
    chk("post.wrap",  32'(wrap16),  32'd0);
    chk("cfg16", 32'(cfg16), 32'd0);
    chk("sat16", 32'(sat16), 32'd0);
    chk("rerr16", 32'(rerr16), 32'd0);
    en16 = 1'b0;

    // Bounded up-wrap, lo=10 hi=20 STEP=3
    load8 = 1'b1; lv8 = 8'd10;
    tick(); load8 = 1'b0;
    chk8("ld10", 8'd10, 1'b0, 1'b0, 1'b0);
    chk("ld10.atlo", 32'(atlo8), 32'd1);
    en8 = 1'b1;
    tick(); chk8("up13", 8'd13, 1'b0, 1'b0, 1'b0);
    tick(); chk8("up16", 8'd16, 1'b0, 1'b0, 1'b0);
    tick(); chk8("up19", 8'd19, 1'b0, 1'b0, 1'b0);
    tick(); chk8("upwrap", 8'd10, 1'b1, 1'b0, 1'b0);
    tick(); chk8("up13b", 8'd13, 1'b0, 1'b0, 1'b0);

    // Down-wrap from 12
    en8 = 1'b0; load8 = 1'b1; lv8 = 8'd12;
    tick(); load8 = 1'b0;
    chk8("ld12", 8'd12, 1'b0, 1'b0, 1'b0);
    en8 = 1'b1; dir8 = 1'b1;
    tick(); chk8("dnwrap", 8'd20, 1'b1, 1'b0, 1'b0);
    chk("dnwrap.athi", 32'(athi8), 32'd1);
    tick(); chk8("dn17", 8'd17, 1'b0, 1'b0, 1'b0);

    // Saturate up from 19, then down from 11
    en8 = 1'b0; dir8 = 1'b0; mode8 = 1'b1; load8 = 1'b1; lv8 = 8'd19;
    tick(); load8 = 1'b0;
    chk8("ld19", 8'd19, 1'b0, 1'b0, 1'b0);
    en8 = 1'b1;
    tick(); chk8("satup1", 8'd20, 1'b0, 1'b1, 1'b0);
    tick(); chk8("satup2", 8'd20, 1'b0, 1'b1, 1'b0);
    en8 = 1'b0;
    tick(); chk8("satidle", 8'd20, 1'b0, 1'b0, 1'b0);
    dir8 = 1'b1; load8 = 1'b1; lv8 = 8'd11;
    tick(); load8 = 1'b0;
    chk8("ld11", 8'd11, 1'b0, 1'b0, 1'b0);
    en8 = 1'b1;
    tick(); chk8("satdn", 8'd10, 1'b0, 1'b1, 1'b0);

    // Load wins over enable
    mode8 = 1'b0; dir8 = 1'b0; load8 = 1'b1; lv8 = 8'd15;
    tick(); load8 = 1'b0;
    chk8("ldpri", 8'd15, 1'b0, 1'b0, 1'b0);

    // Reset on the same edge that would have wrapped
    en8 = 1'b0; load8 = 1'b1; lv8 = 8'd19;
    tick(); load8 = 1'b0; en8 = 1'b1; rst = 1'b1;
    tick(); rst = 1'b0; en8 = 1'b0;
    chk8("rstmid", 8'd0, 1'b0, 1'b0, 1'b0);

    // Bounds shrink under the count
    hi8 = 8'd100; load8 = 1'b1; lv8 = 8'd50;
    tick(); load8 = 1'b0;
    chk8("ld50", 8'd50, 1'b0, 1'b0, 1'b0);
    hi8 = 8'd30; en8 = 1'b1;
    tick(); en8 = 1'b0;
    chk8("oob", 8'd10, 1'b0, 1'b0, 1'b1);

    // Out-of-range load after clearing the sticky flag
    rst = 1'b1; hi8 = 8'd20;
    tick(); rst = 1'b0;
    chk8("clr", 8'd0, 1'b0, 1'b0, 1'b0);
    load8 = 1'b1; lv8 = 8'd25;
    tick(); load8 = 1'b0;
    chk8("ld25", 8'd10, 1'b0, 1'b0, 1'b1);
    en8 = 1'b1;
    tick(); tick(); en8 = 1'b0;
    chk8("sticky", 8'd16, 1'b0, 1'b0, 1'b1);

    // Inverted bounds freeze the counter
    lo8 = 8'd40; hi8 = 8'd30;
    #1 chk("cfg.flag", 32'(cfg8), 32'd1);
    en8 = 1'b1; load8 = 1'b1; lv8 = 8'd35;
    tick(); tick();
    chk8("cfgfrz", 8'd16, 1'b0, 1'b0, 1'b1);
    load8 = 1'b0; en8 = 1'b0;

    // lo == hi wraps in place on every step
    lo8 = 8'd15; hi8 = 8'd15;
    #1 chk("eq.cfg", 32'(cfg8), 32'd0);
    load8 = 1'b1; lv8 = 8'd15;
    tick(); load8 = 1'b0; en8 = 1'b1;
    tick(); chk8("eqwrap1", 8'd15, 1'b1, 1'b0, 1'b1);
    tick(); chk8("eqwrap2", 8'd15, 1'b1, 1'b0, 1'b1);
    chk("eq.atlo", 32'(atlo8), 32'd1);
    chk("eq.athi", 32'(athi8), 32'd1);
    en8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
